// File: rtl/writeback_unit.sv
// LEGv8 writeback stage: picks and formats the retiring result, waits for late load
// data, and drives one registered register-file write port plus a forwarding tap.
module writeback_unit #(
    parameter int WORD     = 64,
    parameter int REG_BITS = 5,
    parameter int ZERO_REG = 31
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          wb_sel,
    input  logic                reg_write,
    input  logic [REG_BITS-1:0] rd,
    input  logic [WORD-1:0]     alu_result,
    input  logic [WORD-1:0]     incremented_pc,
    input  logic [15:0]         imm16,
    input  logic [1:0]          hw,
    input  logic [WORD-1:0]     rd_old,
    input  logic [1:0]          load_size,
    input  logic                load_signed,
    input  logic [WORD-1:0]     read_data,
    input  logic                read_valid,
    output logic                rf_we,
    output logic [REG_BITS-1:0] rf_waddr,
    output logic [WORD-1:0]     rf_wdata,
    output logic                fwd_valid,
    output logic [REG_BITS-1:0] fwd_addr,
    output logic [WORD-1:0]     fwd_data
);

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    localparam logic [2:0] SEL_ALU  = 3'd0;
    localparam logic [2:0] SEL_LOAD = 3'd1;
    localparam logic [2:0] SEL_PC   = 3'd2;
    localparam logic [2:0] SEL_MOVZ = 3'd3;
    localparam logic [2:0] SEL_MOVK = 3'd4;

    state_t              state;
    logic                cap_reg_write;
    logic [REG_BITS-1:0] cap_rd;
    logic [1:0]          cap_size;
    logic                cap_signed;

    function automatic logic [WORD-1:0] format_load(input logic [WORD-1:0] data,
                                                    input logic [1:0] size,
                                                    input logic sgn);
        logic [1:0]      sz;
        int unsigned     bits;
        logic [WORD-1:0] mask;
        sz   = (WORD == 32 && size == 2'd3) ? 2'd2 : size;
        bits = 32'd8 << sz;
        mask = '0;
        for (int unsigned i = 0; i < WORD; i++) mask[i] = (i < bits);
        format_load = data & mask;
        if (sgn && data[bits-1]) format_load = format_load | ~mask;
    endfunction

    function automatic logic [WORD-1:0] format_result(input logic [2:0] sel,
                                                      input logic [WORD-1:0] data);
        logic [1:0]      hw_eff;
        logic [5:0]      shamt;
        logic [WORD-1:0] field;
        hw_eff = (WORD == 32) ? {1'b0, hw[0]} : hw;
        shamt  = {hw_eff, 4'b0000};
        field  = WORD'(imm16) << shamt;
        case (sel)
            SEL_ALU:  format_result = alu_result;
            SEL_LOAD: format_result = format_load(data, load_size, load_signed);
            SEL_PC:   format_result = incremented_pc;
            SEL_MOVZ: format_result = field;
            SEL_MOVK: format_result = (rd_old & ~(WORD'(16'hFFFF) << shamt)) | field;
            default:  format_result = '0;
        endcase
    endfunction

    function automatic logic writes(input logic we, input logic [2:0] sel,
                                    input logic [REG_BITS-1:0] addr);
        writes = we && (sel <= SEL_MOVK) && (addr != REG_BITS'(ZERO_REG));
    endfunction

    always_comb in_ready = (state == IDLE);

    // Loads that arrive with data commit straight from the live inputs; only a
    // missing read_valid parks the load fields and waits.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rf_we         <= 1'b0;
            rf_waddr      <= '0;
            rf_wdata      <= '0;
            cap_reg_write <= 1'b0;
            cap_rd        <= '0;
            cap_size      <= '0;
            cap_signed    <= 1'b0;
        end else begin
            rf_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (wb_sel == SEL_LOAD && !read_valid) begin
                            cap_reg_write <= reg_write;
                            cap_rd        <= rd;
                            cap_size      <= load_size;
                            cap_signed    <= load_signed;
                            state         <= WAIT_MEM;
                        end else if (writes(reg_write, wb_sel, rd)) begin
                            rf_we    <= 1'b1;
                            rf_waddr <= rd;
                            rf_wdata <= format_result(wb_sel, read_data);
                        end
                    end
                end
                WAIT_MEM: begin
                    if (read_valid) begin
                        state <= IDLE;
                        if (writes(cap_reg_write, SEL_LOAD, cap_rd)) begin
                            rf_we    <= 1'b1;
                            rf_waddr <= cap_rd;
                            rf_wdata <= format_load(read_data, cap_size, cap_signed);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        fwd_valid = rf_we;
        fwd_addr  = rf_waddr;
        fwd_data  = rf_wdata;
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: inputs change 1ns after the rising edge and
// outputs are sampled 1ns after the following rising edge.
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  wb_sel;
    logic        reg_write;
    logic [4:0]  rd;
    logic [63:0] alu_result, incremented_pc, rd_old, read_data;
    logic [15:0] imm16;
    logic [1:0]  hw, load_size;
    logic        load_signed, read_valid;
    logic        rf_we, fwd_valid;
    logic [4:0]  rf_waddr, fwd_addr;
    logic [63:0] rf_wdata, fwd_data;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    writeback_unit #(.WORD(64), .REG_BITS(5), .ZERO_REG(31)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .wb_sel(wb_sel), .reg_write(reg_write), .rd(rd), .alu_result(alu_result),
        .incremented_pc(incremented_pc), .imm16(imm16), .hw(hw), .rd_old(rd_old),
        .load_size(load_size), .load_signed(load_signed), .read_data(read_data),
        .read_valid(read_valid), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; wb_sel = 3'd0; reg_write = 1'b1; rd = 5'd0;
        alu_result = '0; incremented_pc = '0; imm16 = '0; hw = '0; rd_old = '0;
        load_size = '0; load_signed = 1'b0; read_data = '0; read_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
        vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b want 0", rf_we); end
        vectors++; if (fwd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_fwd_valid: got %b want 0", fwd_valid); end
        vectors++; if (rf_waddr !== 5'd0) begin miscompares++; $display("FAIL reset_waddr: got %0d want 0", rf_waddr); end
        vectors++; if (rf_wdata !== 64'd0) begin miscompares++; $display("FAIL reset_wdata: got %h want 0", rf_wdata); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_alu();
        in_valid = 1'b1; wb_sel = 3'd0; rd = 5'd3; alu_result = 64'h1234;
        step();
        in_valid = 1'b0;
        vectors++; if (rf_we !== 1'b1) begin miscompares++; $display("FAIL alu_we: got %b want 1", rf_we); end
        vectors++; if (rf_waddr !== 5'd3) begin miscompares++; $display("FAIL alu_waddr: got %0d want 3", rf_waddr); end
        vectors++; if (rf_wdata !== 64'h1234) begin miscompares++; $display("FAIL alu_wdata: got %h want 1234", rf_wdata); end
        vectors++; if (fwd_valid !== 1'b1 || fwd_addr !== 5'd3 || fwd_data !== 64'h1234) begin
            miscompares++; $display("FAIL alu_fwd: got %b/%0d/%h want 1/3/1234", fwd_valid, fwd_addr, fwd_data); end
        step();
        vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL alu_pulse: got %b want 0", rf_we); end
        vectors++; if (rf_wdata !== 64'h1234) begin miscompares++; $display("FAIL alu_hold: got %h want 1234", rf_wdata); end
        // link PC
        in_valid = 1'b1; wb_sel = 3'd2; rd = 5'd30; incremented_pc = 64'h4000_0104;
        step();
        in_valid = 1'b0;
        vectors++; if (rf_we !== 1'b1 || rf_waddr !== 5'd30 || rf_wdata !== 64'h4000_0104) begin
            miscompares++; $display("FAIL link_pc: got %b/%0d/%h want 1/30/40000104", rf_we, rf_waddr, rf_wdata); end
    endtask

    task automatic test_loads();
        logic [1:0]  sizes [5] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
        logic        sgns  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [63:0] datas [5] = '{64'h0000_0000_0000_F080, 64'h0000_0000_0000_F080,
                                   64'h0000_0000_0000_F080, 64'h1234_5678_8765_4321,
                                   64'h1234_5678_8765_4321};
        logic [63:0] exps  [5] = '{64'hFFFF_FFFF_FFFF_FF80, 64'h0000_0000_0000_F080,
                                   64'hFFFF_FFFF_FFFF_F080, 64'hFFFF_FFFF_8765_4321,
                                   64'h1234_5678_8765_4321};
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; wb_sel = 3'd1; rd = 5'(8 + i); read_valid = 1'b1;
            load_size = sizes[i]; load_signed = sgns[i]; read_data = datas[i];
            step();
            vectors++; if (rf_we !== 1'b1 || rf_waddr !== 5'(8 + i) || rf_wdata !== exps[i]) begin
                miscompares++;
                $display("FAIL load_%0d: got %b/%0d/%h want 1/%0d/%h", i, rf_we, rf_waddr, rf_wdata, 8 + i, exps[i]);
            end
        end
        in_valid = 1'b0; read_valid = 1'b0;
        step();
    endtask

    task automatic test_late_load();
        in_valid = 1'b1; wb_sel = 3'd1; rd = 5'd5; load_size = 2'd0; load_signed = 1'b0;
        read_valid = 1'b0; read_data = 64'hFFFF_FFFF_FFFF_FF77;
        step();
        in_valid = 1'b0; wb_sel = 3'd0;
        for (int c = 0; c < 3; c++) begin
            vectors++; if (in_ready !== 1'b0 || rf_we !== 1'b0) begin
                miscompares++; $display("FAIL late_wait_%0d: ready/we got %b/%b want 0/0", c, in_ready, rf_we); end
            if (c == 2) begin read_valid = 1'b1; read_data = 64'hAB; end
            else step();
        end
        // back-to-back ALU op offered in the commit cycle
        step();
        read_valid = 1'b0;
        in_valid = 1'b1; wb_sel = 3'd0; rd = 5'd7; alu_result = 64'h55;
        vectors++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 64'hAB || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL late_commit: got we=%b a=%0d d=%h rdy=%b want 1/5/ab/1", rf_we, rf_waddr, rf_wdata, in_ready); end
        step();
        in_valid = 1'b0;
        vectors++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 64'h55) begin
            miscompares++; $display("FAIL late_b2b: got %b/%0d/%h want 1/7/55", rf_we, rf_waddr, rf_wdata); end
        // stray read_valid in IDLE must not write
        read_valid = 1'b1; read_data = 64'h99;
        step();
        read_valid = 1'b0;
        vectors++; if (rf_we !== 1'b0 || rf_wdata !== 64'h55 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL stray_rvalid: got we=%b d=%h rdy=%b want 0/55/1", rf_we, rf_wdata, in_ready); end
    endtask

    task automatic test_move_wide();
        in_valid = 1'b1; wb_sel = 3'd3; rd = 5'd9; imm16 = 16'hBEEF; hw = 2'd2;
        rd_old = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        wb_sel = 3'd4; rd = 5'd10; hw = 2'd1; rd_old = 64'h1111_2222_3333_4444;
        vectors++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 64'h0000_BEEF_0000_0000) begin
            miscompares++; $display("FAIL movz: got %b/%0d/%h want 1/9/0000beef00000000", rf_we, rf_waddr, rf_wdata); end
        step();
        wb_sel = 3'd4; rd = 5'd11; hw = 2'd3; imm16 = 16'h0A0B; rd_old = 64'h1111_2222_3333_4444;
        vectors++; if (rf_we !== 1'b1 || rf_waddr !== 5'd10 || rf_wdata !== 64'h1111_2222_BEEF_4444) begin
            miscompares++; $display("FAIL movk_hw1: got %b/%0d/%h want 1/10/11112222beef4444", rf_we, rf_waddr, rf_wdata); end
        step();
        in_valid = 1'b0;
        vectors++; if (rf_we !== 1'b1 || rf_waddr !== 5'd11 || rf_wdata !== 64'h0A0B_2222_3333_4444) begin
            miscompares++; $display("FAIL movk_hw3: got %b/%0d/%h want 1/11/0a0b222233334444", rf_we, rf_waddr, rf_wdata); end
    endtask

    task automatic test_no_write();
        logic [2:0] sels [3] = '{3'd0, 3'd0, 3'd6};
        logic [4:0] rds  [3] = '{5'd31, 5'd12, 5'd13};
        logic       wes  [3] = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; wb_sel = sels[i]; rd = rds[i]; reg_write = wes[i];
            alu_result = 64'hDEAD_0000 + 64'(i);
            step();
            vectors++; if (rf_we !== 1'b0 || fwd_valid !== 1'b0 || rf_wdata !== 64'h0A0B_2222_3333_4444) begin
                miscompares++; $display("FAIL nowrite_%0d: got we=%b fwd=%b d=%h want 0/0/0a0b222233334444", i, rf_we, fwd_valid, rf_wdata); end
        end
        in_valid = 1'b0; reg_write = 1'b1;
    endtask

    task automatic test_reset_in_wait();
        in_valid = 1'b1; wb_sel = 3'd1; rd = 5'd14; read_valid = 1'b0;
        step();
        in_valid = 1'b0;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rstwait_pending: ready got %b want 0", in_ready); end
        reset = 1'b1;
        step();
        reset = 1'b0; read_valid = 1'b1; read_data = 64'hCC;
        step();
        read_valid = 1'b0;
        vectors++; if (rf_we !== 1'b0 || in_ready !== 1'b1 || rf_wdata !== 64'd0 || rf_waddr !== 5'd0) begin
            miscompares++; $display("FAIL rstwait: got we=%b rdy=%b a=%0d d=%h want 0/1/0/0", rf_we, in_ready, rf_waddr, rf_wdata); end
        step();
        vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL rstwait_late: we got %b want 0", rf_we); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_loads();
        test_late_load();
        test_move_wide();
        test_no_write();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Registered, parametrised writeback stage for the LEGv8 core: accepts one retiring instruction per handshake, selects and formats the result (ALU, sized/sign-extended load, link PC, MOVZ/MOVK immediate), waits for late load data, and drives a single registered register-file write port plus a forwarding tap. Sits between the memory stage and the register file. It supersedes the combinational writeback mux and adds load-latency tolerance, signed loads, MOVK and XZR suppression.

## Interface
Parameters:
- `WORD`, 64, datapath width; legal values 32 or 64.
- `REG_BITS`, 5, register address width.
- `ZERO_REG`, 31, register index whose writes are discarded (XZR).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream presents an instruction.
- `in_ready`  out  1  stage can accept; equals 1 only in state IDLE.
- `wb_sel`  in  3  0 ALU, 1 LOAD, 2 PC (link), 3 MOVZ, 4 MOVK, 5-7 no write.
- `reg_write`  in  1  instruction writes a register.
- `rd`  in  REG_BITS  destination register.
- `alu_result`  in  WORD  ALU output.
- `incremented_pc`  in  WORD  PC+4.
- `imm16`  in  16  move-wide immediate.
- `hw`  in  2  move-wide shift select (shift = hw*16).
- `rd_old`  in  WORD  current value of `rd` (MOVK only).
- `load_size`  in  2  0 byte, 1 half, 2 word, 3 dword.
- `load_signed`  in  1  sign-extend load result.
- `read_data`  in  WORD  memory read data.
- `read_valid`  in  1  `read_data` valid this cycle.
- `rf_we`  out  1  register-file write enable (registered).
- `rf_waddr`  out  REG_BITS  write address (registered).
- `rf_wdata`  out  WORD  write data (registered).
- `fwd_valid`, `fwd_addr`, `fwd_data`  out  1/REG_BITS/WORD  forwarding copies of `rf_we`/`rf_waddr`/`rf_wdata`.

## Operation
- States: IDLE, WAIT_MEM.
- IDLE: handshake when `in_valid && in_ready`. Capture all inputs. If `wb_sel`=LOAD and `read_valid`=0 -> WAIT_MEM; otherwise commit next edge, stay IDLE.
- WAIT_MEM: `in_ready`=0; captured fields held; `read_data` sampled on first cycle with `read_valid`=1, commit next edge, -> IDLE. `read_valid` in IDLE without a LOAD handshake is ignored.
- Commit: `rf_we` = `reg_write` && `wb_sel`<=4 && `rd`!=`ZERO_REG`; pulse one cycle; `rf_waddr`/`rf_wdata` hold last value when `rf_we`=0.
- Data formatting:
  - ALU: `alu_result`. PC: `incremented_pc`.
  - LOAD: low 8/16/32/WORD bits of `read_data`; zero-extend, or sign-extend from bit 7/15/31 when `load_signed`. With `WORD`=32, size 3 is treated as size 2.
  - MOVZ: `imm16` << (hw*16), other bits 0. MOVK: `rd_old` with bits [hw*16+15:hw*16] replaced by `imm16`. With `WORD`=32, `hw[1]` ignored.
- Reset: state IDLE, `rf_we`=0, `fwd_valid`=0, `rf_waddr`=0, `rf_wdata`=0, `in_ready`=1 from the cycle after reset deasserts. Reset during WAIT_MEM discards the pending load; no write is issued.

## Timing
- Non-load or load with `read_valid` at handshake: handshake edge N, `rf_we`=1 during cycle N+1 (latency 1).
- Late load: `read_valid` first seen at edge M, `rf_we`=1 during cycle M+1; `in_ready` low from N+1 through M, high during M+1, so a new instruction may handshake in the same cycle the load commits.
- Throughput: one instruction per cycle when no load waits.
- `in_ready` is a function of state only (no combinational path from `in_valid`/`read_valid`).
- `fwd_*` equals `rf_*` in every cycle.

## Test plan
- Reset then ALU op: `wb_sel`=0, `rd`=3, `alu_result`=0x1234 -> next cycle `rf_we`=1, `rf_waddr`=3, `rf_wdata`=0x1234; following cycle `rf_we`=0.
- Signed loads: `read_data`=0x00000000_0000F080, size 0 signed -> 0xFFFF_FFFF_FFFF_FF80; size 1 unsigned -> 0xF080; size 1 signed -> 0xFFFF_FFFF_FFFF_F080.
- Late load: LOAD handshake with `read_valid`=0, `read_valid`=1 three cycles later with 0xAB -> `in_ready`=0 for 3 cycles, `rf_we`=1 one cycle after `read_valid`, back-to-back ALU op accepted that cycle commits next.
- Move-wide: MOVZ `imm16`=0xBEEF `hw`=2 -> 0x0000_BEEF_0000_0000; MOVK `rd_old`=0x1111_2222_3333_4444 `hw`=1 `imm16`=0xBEEF -> 0x1111_2222_BEEF_4444.
- XZR/no-write: `rd`=31 ALU op, `reg_write`=0 op, `wb_sel`=6 -> `rf_we` stays 0 each time.
- Reset in WAIT_MEM: LOAD pending, assert `reset` one cycle, then `read_valid`=1 -> no write, `in_ready`=1, `rf_wdata`=0.
